// File: rtl/cal_alu.sv
// Sequential add / shift-add multiply stage behind the calculator controller.
// Optional BCD output and double-dabble conversion enabled by CAL_ALU_BCD_EN.
module cal_alu (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        multi,
  input  logic        add,
  output logic [15:0] result,
  output logic        valid,
  output logic        busy,
`ifdef CAL_ALU_BCD_EN
  output logic [19:0] bcd,
`endif
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_MUL
`ifdef CAL_ALU_BCD_EN
    , S_CONV
`endif
  } state_t;

  state_t      state, state_next;
  logic [1:0]  op, snap_op;
  logic [7:0]  snap_x, snap_y;
  logic        launch;
  logic [15:0] mcand, acc, mul_sum, op_val;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic [8:0]  add_sum;
  logic        op_end;

`ifdef CAL_ALU_BCD_EN
  logic [15:0] fin;
  logic [35:0] dd, dd_adj, dd_shift;
  logic [3:0]  conv_cnt;
`endif

  assign op      = {multi, add};
  // Only a legal op that differs from the last launched one starts work,
  // so held buttons and lingering flags produce a single result.
  assign launch  = ((op == 2'b01) || (op == 2'b10)) &&
                   ({op, x, y} != {snap_op, snap_x, snap_y});
  assign add_sum = {1'b0, mcand[7:0]} + {1'b0, mplier};
  assign mul_sum = acc + (mplier[0] ? mcand : '0);
  assign busy    = (state != S_IDLE);

  always_comb begin
    op_end = (state == S_ADD) || ((state == S_MUL) && (cnt == 3'd7));
    op_val = (state == S_ADD) ? {7'b0, add_sum} : mul_sum;
  end

`ifdef CAL_ALU_BCD_EN
  always_comb begin
    dd_adj = dd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (dd[16 + 4*i +: 4] >= 4'd5)
        dd_adj[16 + 4*i +: 4] = dd[16 + 4*i +: 4] + 4'd3;
    end
    dd_shift = dd_adj << 1;
  end
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (launch) state_next = (op == 2'b01) ? S_ADD : S_MUL;
`ifdef CAL_ALU_BCD_EN
      S_ADD:  state_next = S_CONV;
      S_MUL:  if (cnt == 3'd7) state_next = S_CONV;
      S_CONV: if (conv_cnt == 4'd15) state_next = S_IDLE;
`else
      S_ADD:  state_next = S_IDLE;
      S_MUL:  if (cnt == 3'd7) state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      snap_op  <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
`ifdef CAL_ALU_BCD_EN
      bcd      <= '0;
      fin      <= '0;
      dd       <= '0;
      conv_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            snap_op <= op;
            snap_x  <= x;
            snap_y  <= y;
            mcand   <= {8'b0, x};
            mplier  <= y;
            acc     <= '0;
            cnt     <= '0;
          end else if (op == 2'b00) begin
            result  <= '0;
            valid   <= 1'b0;
            snap_op <= '0;
            snap_x  <= '0;
            snap_y  <= '0;
`ifdef CAL_ALU_BCD_EN
            bcd     <= '0;
`endif
          end
        end
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
        end
`ifdef CAL_ALU_BCD_EN
        S_CONV: begin
          dd       <= dd_shift;
          conv_cnt <= conv_cnt + 4'd1;
          if (conv_cnt == 4'd15) begin
            result <= fin;
            bcd    <= dd_shift[35:16];
            valid  <= 1'b1;
            done   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (op_end) begin
`ifdef CAL_ALU_BCD_EN
        fin      <= op_val;
        dd       <= {20'b0, op_val};
        conv_cnt <= '0;
`else
        result   <= op_val;
        valid    <= 1'b1;
        done     <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cal_alu.sv
// Scoreboard bench for cal_alu: stimulus pushes expected results with their
// completion cycle; a monitor pops and compares on every done pulse.
module tb_cal_alu;

`ifdef CAL_ALU_BCD_EN
  localparam int LADD = 17;
  localparam int LMUL = 24;
`else
  localparam int LADD = 1;
  localparam int LMUL = 8;
`endif

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [7:0]  x, y;
  logic        multi, add;
  logic [15:0] result;
  logic        valid, busy, done;
`ifdef CAL_ALU_BCD_EN
  logic [19:0] bcd;
`endif

  typedef struct {
    logic [15:0] res;
    logic [19:0] bcdv;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  cal_alu dut (
    .mclk   (mclk),
    .rst_n  (rst_n),
    .x      (x),
    .y      (y),
    .multi  (multi),
    .add    (add),
    .result (result),
    .valid  (valid),
    .busy   (busy),
`ifdef CAL_ALU_BCD_EN
    .bcd    (bcd),
`endif
    .done   (done)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge mclk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none, result %0h", cyc, result);
      end else begin
        e = q.pop_front();
        chk("result", {16'b0, result}, {16'b0, e.res});
        chk("done_cycle", cyc, e.cyc);
        chk("valid_at_done", {31'b0, valid}, 32'd1);
`ifdef CAL_ALU_BCD_EN
        chk("bcd", {12'b0, bcd}, {12'b0, e.bcdv});
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic push(input logic [15:0] res, input logic [19:0] bcdv, input int c);
    exp_t e;
    e.res  = res;
    e.bcdv = bcdv;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 120 && q.size() != 0; i++) @(negedge mclk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    tick(1);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_result"}, {16'b0, result}, 32'd0);
    chk({name, "_valid"}, {31'b0, valid}, 32'd0);
`ifdef CAL_ALU_BCD_EN
    chk({name, "_bcd"}, {12'b0, bcd}, 32'd0);
`endif
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; x = '0; y = '0; multi = 1'b0; add = 1'b0;
    tick(3);
    chk_cleared("reset");
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 200 + 100
    x = 8'd200; y = 8'd100; add = 1'b1;
    push(16'd300, 20'h00300, cyc + 1 + LADD);
    tick(1);
    chk("add_busy", {31'b0, busy}, 32'd1);
    wait_idle();
    chk("add_busy_after", {31'b0, busy}, 32'd0);
    tick(5);
    add = 1'b0;
    tick(2);
    chk_cleared("clear_after_add");

    // 255 * 255
    x = 8'd255; y = 8'd255; multi = 1'b1;
    push(16'hFE01, 20'h65025, cyc + 1 + LMUL);
    tick(1);
    chk("mul_busy", {31'b0, busy}, 32'd1);
    wait_idle();
    multi = 1'b0;
    tick(2);

    // Held 3 * 4: exactly one result, then y change relaunches
    x = 8'd3; y = 8'd4; multi = 1'b1;
    push(16'd12, 20'h00012, cyc + 1 + LMUL);
    tick(50);
    chk("hold_pending", q.size(), 32'd0);
    y = 8'd5;
    push(16'd15, 20'h00015, cyc + 1 + LMUL);
    wait_idle();

    // y changes during 7 * 6; the new value launches right after completion
    x = 8'd7; y = 8'd6;
    c0 = cyc;
    push(16'd42, 20'h00042, c0 + 1 + LMUL);
    push(16'd63, 20'h00063, c0 + 2 + 2 * LMUL);
    tick(3);
    y = 8'd9;
    wait_idle();
    wait_idle();

    // Reset mid-multiply, then unchanged inputs relaunch
    x = 8'd13; y = 8'd11;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midreset_result", {16'b0, result}, 32'd0);
    chk("midreset_valid", {31'b0, valid}, 32'd0);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    push(16'd143, 20'h00143, cyc + 1 + LMUL);
    wait_idle();

    // Illegal op never launches
    add = 1'b1; multi = 1'b1; x = 8'd1; y = 8'd2;
    tick(1);
    chk("illegal_busy", {31'b0, busy}, 32'd0);
    tick(4);
    chk("illegal_busy_later", {31'b0, busy}, 32'd0);
    chk("illegal_result", {16'b0, result}, 32'd143);
    add = 1'b0; multi = 1'b0;
    tick(2);
    chk_cleared("clear_after_illegal");

    tick(2);
    chk("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
